// File: rtl/matmul_uart_ctrl.sv
// Frame controller for the 10x10 binary matrix multiplier: gathers operands A/B from
// UART bytes, pulses start, captures the 400-bit result and streams it out as 50 bytes.
module matmul_uart_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int MUL_LATENCY  = 2,
  parameter int RX_TIMEOUT   = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         tx_done,
  input  logic [399:0] result,
  output logic [99:0]  matrixA,
  output logic [99:0]  matrixB,
  output logic         start,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  output logic         busy,
  output logic         done,
  output logic         rx_overrun,
  output logic [2:0]   state
);

  localparam int IDLE_W = ($clog2(RX_TIMEOUT + 32'd1) > 32'd20) ? $clog2(RX_TIMEOUT + 32'd1) : 32'd20;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    RUN     = 3'd2,
    WAIT    = 3'd3,
    SEND    = 3'd4,
    TX_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [5:0]          cnt_r, cnt_s;
  logic [IDLE_W-1:0]   idle_r, idle_s;
  logic [7:0]          tmr_r, tmr_s;
  logic [399:0]        buf_r, buf_s;
  logic [99:0]         mat_a_r, mat_a_s;
  logic [99:0]         mat_b_r, mat_b_s;
  logic                start_r, tx_start_r, busy_r, done_r;
  logic [7:0]          tx_data_r;
  logic                in_load_s, timeout_armed_s;

  // Byte n lands at [8n+7:8n]; byte 12 only fills the top nibble [99:96].
  function automatic logic [99:0] write_byte(input logic [99:0] m, input logic [5:0] n,
                                             input logic [7:0] d);
    logic [99:0] r;
    r = m;
    for (int i = 0; i < 12; i++) begin
      r[8*i +: 8] = (n == 6'(i)) ? d : m[8*i +: 8];
    end
    r[99:96] = (n == 6'd12) ? d[3:0] : m[99:96];
    return r;
  endfunction

  assign in_load_s       = (state_r == LOAD_A) || (state_r == LOAD_B);
  assign timeout_armed_s = (RX_TIMEOUT != 0) && ((state_r == LOAD_B) || (cnt_r != 6'd0));

  // Next-state, counters, operand assembly and result shift buffer
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idle_s  = IDLE_W'(0);
    tmr_s   = 8'd0;
    buf_s   = buf_r;
    mat_a_s = mat_a_r;
    mat_b_s = mat_b_r;
    case (state_r)
      LOAD_A, LOAD_B: begin
        if (rx_valid) begin
          if (state_r == LOAD_A) begin
            mat_a_s = write_byte(mat_a_r, cnt_r, rx_data);
          end else begin
            mat_b_s = write_byte(mat_b_r, cnt_r, rx_data);
          end
          if (cnt_r == 6'd12) begin
            state_s = (state_r == LOAD_A) ? LOAD_B : RUN;
            cnt_s   = 6'd0;
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end else if (timeout_armed_s) begin
          // Partial frame abandoned; operand registers keep what already arrived.
          if (idle_r == IDLE_W'(RX_TIMEOUT - 1)) begin
            state_s = LOAD_A;
            cnt_s   = 6'd0;
          end else begin
            idle_s = idle_r + IDLE_W'(1);
          end
        end else begin
          idle_s = IDLE_W'(0);
        end
      end
      RUN: begin
        if (tmr_r == 8'(START_CYCLES - 1)) begin
          state_s = WAIT;
        end else begin
          tmr_s = tmr_r + 8'd1;
        end
      end
      WAIT: begin
        if (tmr_r == 8'(MUL_LATENCY - 1)) begin
          buf_s   = result;
          state_s = SEND;
        end else begin
          tmr_s = tmr_r + 8'd1;
        end
      end
      SEND: begin
        state_s = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          buf_s   = {8'h00, buf_r[399:8]};
          cnt_s   = cnt_r + 6'd1;
          state_s = (cnt_r == 6'd49) ? DONE : SEND;
        end else begin
          state_s = TX_WAIT;
        end
      end
      DONE: begin
        state_s = LOAD_A;
        cnt_s   = 6'd0;
      end
      default: begin
        state_s = LOAD_A;
        cnt_s   = 6'd0;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= LOAD_A;
      cnt_r      <= 6'd0;
      idle_r     <= IDLE_W'(0);
      tmr_r      <= 8'd0;
      buf_r      <= 400'd0;
      mat_a_r    <= 100'd0;
      mat_b_r    <= 100'd0;
      start_r    <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idle_r     <= idle_s;
      tmr_r      <= tmr_s;
      buf_r      <= buf_s;
      mat_a_r    <= mat_a_s;
      mat_b_r    <= mat_b_s;
      start_r    <= (state_s == RUN);
      tx_start_r <= (state_s == SEND);
      tx_data_r  <= (state_s == SEND) ? buf_s[7:0] : tx_data_r;
      busy_r     <= !((state_s == LOAD_A) && (cnt_s == 6'd0));
      done_r     <= (state_s == DONE);
    end
  end

  assign matrixA    = mat_a_r;
  assign matrixB    = mat_b_r;
  assign start      = start_r;
  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign state      = state_r;
  assign rx_overrun = rx_valid && !in_load_s;

endmodule
